// File: rtl/proc_z_core.sv
// proc_z_core: four-stage in-order core (Fetch/Decode/Execute/Writeback) over a 512x32 instruction RAM.
// Define PROC_Z_FORWARD_EN to bypass Execute/Writeback results into Decode operands.
module proc_z_core (
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic        working,
  input  logic [3:0]  rID,
  output logic [31:0] valE,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic [31:0] r3,
  output logic [31:0] r4,
  output logic [31:0] r5,
  output logic [31:0] r6,
  output logic [31:0] r7,
  output logic [31:0] rdata
);

  typedef enum logic [2:0] {OpNop, OpIrmov, OpAdd, OpSub, OpAnd, OpXor} opKind;

  logic [31:0] mem [512];
  logic [8:0]  pc;
  logic [31:0] fetchWord;
  logic        decValid;
  logic [31:0] regs [8];

  opKind       decOp;
  logic [31:0] srcVal [16];
  logic [31:0] decA;
  logic [31:0] decB;

  opKind       exeOp;
  logic [31:0] exeA;
  logic [31:0] exeB;
  logic [3:0]  exeDst;
  logic        exeWen;
  logic [31:0] exeResult;

  logic        wbWen;
  logic [2:0]  wbDst;
  logic [31:0] wbVal;

  // RAM has no reset so its contents survive reset.
  always_ff @(posedge clock) begin
    if (wr && !working && !reset) mem[addr] <= wdata;
    if (working) fetchWord <= mem[pc];
  end

  always_comb begin
    decOp = OpNop;
    if (decValid) begin
      case (fetchWord[31:24])
        8'h10:   decOp = OpIrmov;
        8'h20:   decOp = OpAdd;
        8'h21:   decOp = OpSub;
        8'h22:   decOp = OpAnd;
        8'h23:   decOp = OpXor;
        default: decOp = OpNop;
      endcase
    end
  end

  always_comb begin
    valE = '0;
    case (exeOp)
      OpAdd:   valE = exeA + exeB;
      OpSub:   valE = exeA - exeB;
      OpAnd:   valE = exeA & exeB;
      OpXor:   valE = exeA ^ exeB;
      default: valE = '0;
    endcase
  end

  assign exeWen    = (exeOp != OpNop) && !exeDst[3];
  assign exeResult = (exeOp == OpIrmov) ? exeB : valE;

  // Operand read; Execute overrides Writeback so the youngest producer wins.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      srcVal[i] = (i < 8) ? regs[i[2:0]] : '0;
`ifdef PROC_Z_FORWARD_EN
      if (i < 8 && wbWen && wbDst == i[2:0]) srcVal[i] = wbVal;
      if (i < 8 && exeWen && exeDst == i[3:0]) srcVal[i] = exeResult;
`endif
    end
  end

  assign decA = srcVal[fetchWord[23:20]];
  assign decB = srcVal[fetchWord[19:16]];

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= '0;
      decValid <= 1'b0;
      exeOp    <= OpNop;
      exeA     <= '0;
      exeB     <= '0;
      exeDst   <= '0;
      wbWen    <= 1'b0;
      wbDst    <= '0;
      wbVal    <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (working) pc <= pc + 9'd1;
      decValid <= working;
      exeOp    <= decOp;
      exeA     <= decA;
      exeB     <= (decOp == OpIrmov) ? {16'h0000, fetchWord[15:0]} : decB;
      exeDst   <= (decOp == OpIrmov) ? fetchWord[19:16] : fetchWord[23:20];
      wbWen    <= exeWen;
      wbDst    <= exeDst[2:0];
      wbVal    <= exeResult;
      if (wbWen) regs[wbDst] <= wbVal;
    end
  end

  assign r0    = regs[0];
  assign r1    = regs[1];
  assign r2    = regs[2];
  assign r3    = regs[3];
  assign r4    = regs[4];
  assign r5    = regs[5];
  assign r6    = regs[6];
  assign r7    = regs[7];
  assign rdata = rID[3] ? 32'h0 : regs[rID[2:0]];

endmodule

// File: tb/tb_proc_z_core.sv
// Randomized bench for proc_z_core against a slot-level model: each cycle issues one slot
// (fetched word or bubble) that commits three edges later.
module tb_proc_z_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  addr;
  logic        wr;
  logic [31:0] wdata;
  logic        working;
  logic [3:0]  rID;
  logic [31:0] valE, r0, r1, r2, r3, r4, r5, r6, r7, rdata;

  proc_z_core dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .wr      (wr),
    .wdata   (wdata),
    .working (working),
    .rID     (rID),
    .valE    (valE),
    .r0      (r0),
    .r1      (r1),
    .r2      (r2),
    .r3      (r3),
    .r4      (r4),
    .r5      (r5),
    .r6      (r6),
    .r7      (r7),
    .rdata   (rdata)
  );

  always #5 clock = ~clock;

  typedef logic [7:0][31:0] regFile_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
  } slot_t;

  int tests = 0;
  int fails = 0;

  logic [31:0] mMem [512];
  regFile_t    mReg;
  logic [8:0]  mPc;
  slot_t       mPipe [$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd(input regFile_t rf, input logic [3:0] idx);
    return idx[3] ? 32'h0 : rf[idx[2:0]];
  endfunction

  // Forwarding: operands are the architectural state just before the slot commits.
  // Otherwise: operands are the register contents at the time the slot was issued.
  function automatic void operands(input regFile_t rf, input slot_t s,
                                   output logic [31:0] a, output logic [31:0] b);
`ifdef PROC_Z_FORWARD_EN
    a = rd(rf, s.instr[23:20]);
    b = rd(rf, s.instr[19:16]);
`else
    a = s.a;
    b = s.b;
`endif
  endfunction

  function automatic logic [31:0] aluOf(input regFile_t rf, input slot_t s);
    logic [31:0] a, b;
    operands(rf, s, a, b);
    case (s.instr[31:24])
      8'h20:   return a + b;
      8'h21:   return a - b;
      8'h22:   return a & b;
      8'h23:   return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic regFile_t applySlot(input regFile_t rf, input slot_t s);
    regFile_t    nrf;
    logic [3:0]  ra, rb;
    nrf = rf;
    ra  = s.instr[23:20];
    rb  = s.instr[19:16];
    if (s.instr[31:24] == 8'h10) begin
      if (!rb[3]) nrf[rb[2:0]] = {16'h0, s.instr[15:0]};
    end else if (s.instr[31:26] == 6'b001000) begin
      if (!ra[3]) nrf[ra[2:0]] = aluOf(rf, s);
    end
    return nrf;
  endfunction

  task automatic modelEdge();
    slot_t s, old;
    if (reset) begin
      mPc  = '0;
      mReg = '0;
      mPipe.delete();
      for (int i = 0; i < 3; i++) mPipe.push_back('0);
    end else begin
      old  = mPipe.pop_front();
      mReg = applySlot(mReg, old);
      s.instr = working ? mMem[mPc] : 32'h0;
      if (working) mPc = mPc + 9'd1;
      s.a = rd(mReg, s.instr[23:20]);
      s.b = rd(mReg, s.instr[19:16]);
      mPipe.push_back(s);
    end
    if (wr && !working && !reset) mMem[addr] = wdata;
  endtask

  task automatic checkAll();
    regFile_t dutRegs;
    dutRegs = {r7, r6, r5, r4, r3, r2, r1, r0};
    for (int i = 0; i < 8; i++) checkVal($sformatf("r%0d", i), dutRegs[i], mReg[i]);
    checkVal($sformatf("rdata[rID=%0d]", rID), rdata, rd(mReg, rID));
    checkVal("valE", valE, aluOf(applySlot(mReg, mPipe[0]), mPipe[1]));
  endtask

  task automatic step();
    @(posedge clock);
    modelEdge();
    #1;
    checkAll();
    rID = 4'($urandom);
  endtask

  task automatic loadWord(input logic [8:0] a, input logic [31:0] d);
    working = 1'b0;
    wr      = 1'b1;
    addr    = a;
    wdata   = d;
    step();
    wr = 1'b0;
  endtask

  task automatic runFor(input logic w, input int n);
    working = w;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic checkProgramResult(input string tag);
    checkVal({tag, " r0"}, r0, 32'h0000_0101);
    checkVal({tag, " r1"}, r1, 32'h0000_0081);
    checkVal({tag, " r2"}, r2, 32'hFFFF_FFFF);
    checkVal({tag, " r3"}, r3, 32'h0000_0083);
    checkVal({tag, " r4"}, r4, 32'h0000_0084);
    checkVal({tag, " r5"}, r5, 32'h0000_0001);
    checkVal({tag, " r6"}, r6, 32'h0000_0001);
    checkVal({tag, " r7"}, r7, 32'h0000_0087);
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    int k;
    k = $urandom_range(0, 9);
    w = $urandom;
    if (k <= 2)      w[31:24] = 8'h10;
    else if (k <= 7) w[31:24] = 8'h20 + 8'($urandom_range(0, 3));
    else if (k == 8) w = 32'h0;
    if (k <= 7) begin
      w[23:20] = 4'($urandom_range(0, 9));
      w[19:16] = 4'($urandom_range(0, 9));
    end
    return w;
  endfunction

  initial begin
    reset   = 1'b1;
    working = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    wdata   = '0;
    rID     = '0;
    runFor(1'b0, 2);
    checkVal("reset valE", valE, 32'h0);
    checkVal("reset r0", r0, 32'h0);
    reset = 1'b0;

    // Directed program: eight IRMOVs, four ALU ops, then a dependent SUB.
    for (int a = 0; a < 512; a++) begin
      if (a < 8)        loadWord(9'(a), 32'h10F0_0080 | (32'(a) << 16) | 32'(a));
      else if (a == 8)  loadWord(9'(a), 32'h2001_0000);
      else if (a == 9)  loadWord(9'(a), 32'h2123_0000);
      else if (a == 10) loadWord(9'(a), 32'h2245_0000);
      else if (a == 11) loadWord(9'(a), 32'h2367_0000);
      else if (a == 12) loadWord(9'(a), 32'h2154_0000);
      else if (a == 13) loadWord(9'(a), 32'h10F8_0055);
      else              loadWord(9'(a), 32'h0);
    end

    // Run with a write attempt to RAM[0] that must be ignored.
    runFor(1'b1, 3);
    wr = 1'b1; addr = 9'd0; wdata = 32'hFFFF_FFFF;
    runFor(1'b1, 3);
    wr = 1'b0;
    runFor(1'b1, 10);
    runFor(1'b0, 4);
    checkProgramResult("run1");

    // Reset mid-run (with working high), then halt with instructions in flight.
    reset = 1'b1;
    runFor(1'b1, 1);
    reset = 1'b0;
    runFor(1'b1, 6);
    reset = 1'b1;
    runFor(1'b1, 1);
    reset = 1'b0;
    checkVal("mid-run reset r0", r0, 32'h0);
    runFor(1'b1, 5);
    runFor(1'b0, 5);
    runFor(1'b1, 12);
    runFor(1'b0, 4);
    checkProgramResult("run2");

    // Random programs with random halts, ignored writes, reloads and resets.
    for (int a = 0; a < 512; a++) loadWord(9'(a), randInstr());
    reset = 1'b1;
    runFor(1'b0, 1);
    reset = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      reset   = ($urandom_range(0, 199) == 0);
      working = ($urandom_range(0, 7) != 0);
      wr      = ($urandom_range(0, 3) == 0);
      addr    = 9'($urandom);
      wdata   = randInstr();
      step();
    end
    wr = 1'b0;
    reset = 1'b0;
    runFor(1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
